// File: rtl/vote_tally.sv
// Election tally: counts one-hot votes during an open session, then scans the
// tallies one candidate per cycle to report the winner and whether it is a tie.
module vote_tally #(
   parameter int NUM_CAND = 4,
   parameter int CNT_W    = 21,
   parameter int IDX_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      open,
   input  logic                      close,
   input  logic [NUM_CAND-1:0]       vote,
   output logic                      vote_ok,
   output logic                      vote_rej,
   output logic [1:0]                state,
   output logic [NUM_CAND*CNT_W-1:0] counts,
   output logic [CNT_W-1:0]          total,
   output logic [CNT_W-1:0]          rej_count,
   output logic [IDX_W-1:0]          winner,
   output logic                      tie,
   output logic                      result_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OPEN = 2'd1,
      S_SCAN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [NUM_CAND];
   logic [CNT_W-1:0] cnt_d [NUM_CAND];
   logic [CNT_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] rej_q, rej_d;
   logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
   logic [CNT_W-1:0] best_val_q, best_val_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             tie_q, tie_d;
   logic             vote_ok_q, vote_rej_q;

   logic             start_session, start_scan;
   logic             vote_req, vote_multi, seen;
   logic [IDX_W-1:0] tgt_idx;
   logic             tgt_sat, accept, reject;
   logic [CNT_W-1:0] cur_val;

   always_comb begin
      state_d       = state_q;
      start_session = 1'b0;
      start_scan    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (open) begin
               state_d       = S_OPEN;
               start_session = 1'b1;
            end
         end
         S_OPEN: begin
            // close has priority over a simultaneous open
            if (close) begin
               state_d    = S_SCAN;
               start_scan = 1'b1;
            end
         end
         S_SCAN: begin
            if (scan_idx_q == LAST_IDX) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      vote_req   = |vote;
      vote_multi = 1'b0;
      seen       = 1'b0;
      tgt_idx    = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (vote[i]) begin
            if (seen) vote_multi = 1'b1;
            seen    = 1'b1;
            tgt_idx = IDX_W'(i);
         end
      end
   end

   // A vote sampled on the close edge is still judged as an OPEN-state vote.
   assign tgt_sat = (cnt_q[tgt_idx] == CNT_MAX);
   assign accept  = vote_req && (state_q == S_OPEN) && !vote_multi && !tgt_sat;
   assign reject  = vote_req && !accept;
   assign cur_val = cnt_q[scan_idx_q];

   always_comb begin
      cnt_d      = cnt_q;
      total_d    = total_q;
      rej_d      = rej_q;
      scan_idx_d = scan_idx_q;
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
      tie_d      = tie_q;
      if (start_session) begin
         for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = '0;
         total_d    = '0;
         rej_d      = '0;
         best_idx_d = '0;
         tie_d      = 1'b0;
      end
      if (accept) begin
         cnt_d[tgt_idx] = cnt_q[tgt_idx] + CNT_W'(1);
         if (total_q != CNT_MAX) total_d = total_q + CNT_W'(1);
      end
      if (reject && (rej_d != CNT_MAX)) rej_d = rej_d + CNT_W'(1);
      if (start_scan) begin
         scan_idx_d = '0;
         best_val_d = '0;
         best_idx_d = '0;
         tie_d      = 1'b0;
      end
      if (state_q == S_SCAN) begin
         scan_idx_d = scan_idx_q + IDX_W'(1);
         // Equal tallies keep the earlier (lower) index and flag a tie.
         if (cur_val > best_val_q) begin
            best_val_d = cur_val;
            best_idx_d = scan_idx_q;
            tie_d      = 1'b0;
         end else if (cur_val == best_val_q) begin
            tie_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
         total_q    <= '0;
         rej_q      <= '0;
         scan_idx_q <= '0;
         best_val_q <= '0;
         best_idx_q <= '0;
         tie_q      <= 1'b0;
         vote_ok_q  <= 1'b0;
         vote_rej_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         total_q    <= total_d;
         rej_q      <= rej_d;
         scan_idx_q <= scan_idx_d;
         best_val_q <= best_val_d;
         best_idx_q <= best_idx_d;
         tie_q      <= tie_d;
         vote_ok_q  <= accept;
         vote_rej_q <= reject;
      end
   end

   always_comb begin
      counts = '0;
      for (int i = 0; i < NUM_CAND; i++) counts[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   assign state        = state_q;
   assign total        = total_q;
   assign rej_count    = rej_q;
   assign winner       = best_idx_q;
   assign tie          = tie_q;
   assign vote_ok      = vote_ok_q;
   assign vote_rej     = vote_rej_q;
   assign result_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: per-cycle vector table plus directed multi-cycle
// sequences on three configurations (default, 3-bit counters, 8 candidates).
module tb_vote_tally;

   logic clk = 1'b0;
   logic rst, open, close;
   logic [3:0] vote4;
   logic [7:0] vote8;

   int checks = 0;
   int errors = 0;

   // default configuration
   logic        a_ok, a_rej, a_tie, a_rv;
   logic [1:0]  a_state, a_win;
   logic [83:0] a_counts;
   logic [20:0] a_total, a_rc;

   // narrow counters for saturation
   logic        s_ok, s_rej, s_tie, s_rv;
   logic [1:0]  s_state, s_win;
   logic [11:0] s_counts;
   logic [2:0]  s_total, s_rc;

   // eight candidates
   logic         e_ok, e_rej, e_tie, e_rv;
   logic [1:0]   e_state;
   logic [2:0]   e_win;
   logic [167:0] e_counts;
   logic [20:0]  e_total, e_rc;

   vote_tally u_a (
      .clk(clk), .rst(rst), .open(open), .close(close), .vote(vote4),
      .vote_ok(a_ok), .vote_rej(a_rej), .state(a_state), .counts(a_counts),
      .total(a_total), .rej_count(a_rc), .winner(a_win), .tie(a_tie),
      .result_valid(a_rv)
   );

   vote_tally #(.NUM_CAND(4), .CNT_W(3), .IDX_W(2)) u_s (
      .clk(clk), .rst(rst), .open(open), .close(close), .vote(vote4),
      .vote_ok(s_ok), .vote_rej(s_rej), .state(s_state), .counts(s_counts),
      .total(s_total), .rej_count(s_rc), .winner(s_win), .tie(s_tie),
      .result_valid(s_rv)
   );

   vote_tally #(.NUM_CAND(8), .CNT_W(21), .IDX_W(3)) u_e (
      .clk(clk), .rst(rst), .open(open), .close(close), .vote(vote8),
      .vote_ok(e_ok), .vote_rej(e_rej), .state(e_state), .counts(e_counts),
      .total(e_total), .rej_count(e_rc), .winner(e_win), .tie(e_tie),
      .result_valid(e_rv)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       r, o, c;
      logic [3:0] v;
      logic [1:0] st;
      logic       ok, rj, rv;
      int         tot, rc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, o, c, input logic [3:0] v,
                               input logic [1:0] st, input logic ok, rj, rv,
                               input int tot, rc);
      vec_t x;
      x.r = r; x.o = o; x.c = c; x.v = v;
      x.st = st; x.ok = ok; x.rj = rj; x.rv = rv; x.tot = tot; x.rc = rc;
      vecs.push_back(x);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Apply inputs at a falling edge; return at the next falling edge so the
   // outputs reflect the rising edge in between.
   task automatic cyc(input logic r, o, c, input logic [3:0] v4, input logic [7:0] v8);
      rst = r; open = o; close = c; vote4 = v4; vote8 = v8;
      @(negedge clk);
   endtask

   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].r, vecs[i].o, vecs[i].c, vecs[i].v, 8'd0);
         chk($sformatf("%s[%0d].state", tag, i), a_state, vecs[i].st);
         chk($sformatf("%s[%0d].vote_ok", tag, i), a_ok, vecs[i].ok);
         chk($sformatf("%s[%0d].vote_rej", tag, i), a_rej, vecs[i].rj);
         chk($sformatf("%s[%0d].result_valid", tag, i), a_rv, vecs[i].rv);
         chk($sformatf("%s[%0d].total", tag, i), a_total, vecs[i].tot);
         chk($sformatf("%s[%0d].rej_count", tag, i), a_rc, vecs[i].rc);
      end
   endtask

   // Counts edges from the close edge (edge 1) until result_valid is seen.
   task automatic wait_rv(input bit eight, input string nm, input int exp_edges);
      int n = 1;
      while (!(eight ? e_rv : a_rv) && n < 40) begin
         cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
         n++;
      end
      chk(nm, n, exp_edges);
   endtask

   int ok_n, rej_n;

   initial begin
      rst = 1'b1; open = 1'b0; close = 1'b0; vote4 = '0; vote8 = '0;
      @(negedge clk);

      // basic session: votes 2,2,1,3,2 then scan
      vecs.delete();
      add(1,0,0,4'b0000, 0, 0,0,0, 0,0);
      add(0,1,0,4'b0000, 1, 0,0,0, 0,0);
      add(0,0,0,4'b0100, 1, 1,0,0, 1,0);
      add(0,0,0,4'b0100, 1, 1,0,0, 2,0);
      add(0,0,0,4'b0010, 1, 1,0,0, 3,0);
      add(0,0,0,4'b1000, 1, 1,0,0, 4,0);
      add(0,0,0,4'b0100, 1, 1,0,0, 5,0);
      add(0,0,1,4'b0000, 2, 0,0,0, 5,0);
      add(0,0,0,4'b0000, 2, 0,0,0, 5,0);
      add(0,0,0,4'b0000, 2, 0,0,0, 5,0);
      add(0,0,0,4'b0000, 2, 0,0,0, 5,0);
      add(0,0,0,4'b0000, 3, 0,0,1, 5,0);
      add(0,0,0,4'b0000, 3, 0,0,1, 5,0);
      run_vecs("basic");
      chk("basic.count0", a_counts[0*21 +: 21], 0);
      chk("basic.count1", a_counts[1*21 +: 21], 1);
      chk("basic.count2", a_counts[2*21 +: 21], 3);
      chk("basic.count3", a_counts[3*21 +: 21], 1);
      chk("basic.winner", a_win, 2);
      chk("basic.tie", a_tie, 0);

      // rejection: multi-hot in OPEN, then a vote in DONE, then a vote in IDLE
      vecs.delete();
      add(1,0,0,4'b0000, 0, 0,0,0, 0,0);
      add(0,1,0,4'b0000, 1, 0,0,0, 0,0);
      add(0,0,0,4'b0110, 1, 0,1,0, 0,1);
      add(0,0,0,4'b0000, 1, 0,0,0, 0,1);
      add(0,0,1,4'b0000, 2, 0,0,0, 0,1);
      add(0,0,0,4'b0000, 2, 0,0,0, 0,1);
      add(0,0,0,4'b0000, 2, 0,0,0, 0,1);
      add(0,0,0,4'b0000, 2, 0,0,0, 0,1);
      add(0,0,0,4'b0000, 3, 0,0,1, 0,1);
      add(0,0,0,4'b0001, 3, 0,1,1, 0,2);
      add(0,0,0,4'b0000, 3, 0,0,1, 0,2);
      add(1,0,0,4'b0000, 0, 0,0,0, 0,0);
      add(0,0,0,4'b0001, 0, 0,1,0, 0,1);
      add(0,0,0,4'b0000, 0, 0,0,0, 0,1);
      add(0,0,1,4'b0000, 0, 0,0,0, 0,1);
      run_vecs("reject");

      // tie between candidates 0 and 3
      cyc(1,0,0,4'b0000,8'd0);
      cyc(0,1,0,4'b0000,8'd0);
      cyc(0,0,0,4'b0001,8'd0);
      cyc(0,0,0,4'b1000,8'd0);
      cyc(0,0,0,4'b1000,8'd0);
      cyc(0,0,0,4'b0001,8'd0);
      cyc(0,0,1,4'b0000,8'd0);
      wait_rv(1'b0, "tie.latency", 5);
      chk("tie.winner", a_win, 0);
      chk("tie.tie", a_tie, 1);

      // reopen from DONE clears, then an empty session
      cyc(0,1,0,4'b0000,8'd0);
      chk("reopen.state", a_state, 1);
      chk("reopen.counts", a_counts, 0);
      chk("reopen.tie", a_tie, 0);
      chk("reopen.rv", a_rv, 0);
      cyc(0,0,1,4'b0000,8'd0);
      wait_rv(1'b0, "empty.latency", 5);
      chk("empty.winner", a_win, 0);
      chk("empty.tie", a_tie, 1);
      chk("empty.total", a_total, 0);

      // saturation with 3-bit counters: 9 votes for candidate 1
      cyc(1,0,0,4'b0000,8'd0);
      cyc(0,1,0,4'b0000,8'd0);
      ok_n = 0; rej_n = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(0,0,0,4'b0010,8'd0);
         if (s_ok) ok_n++;
         if (s_rej) rej_n++;
         chk($sformatf("sat[%0d].exclusive", i), s_ok & s_rej, 0);
      end
      cyc(0,0,0,4'b0000,8'd0);
      chk("sat.ok_idle", s_ok, 0);
      chk("sat.rej_idle", s_rej, 0);
      chk("sat.count1", s_counts[1*3 +: 3], 7);
      chk("sat.ok_pulses", ok_n, 7);
      chk("sat.rej_pulses", rej_n, 2);
      chk("sat.rej_count", s_rc, 2);
      chk("sat.total", s_total, 7);

      // open+close with a vote in OPEN, open ignored in SCAN, reset mid-SCAN
      cyc(1,0,0,4'b0000,8'd0);
      cyc(0,1,0,4'b0000,8'd0);
      cyc(0,1,1,4'b1000,8'd0);
      chk("simul.state", a_state, 2);
      chk("simul.count3", a_counts[3*21 +: 21], 1);
      chk("simul.total", a_total, 1);
      chk("simul.vote_ok", a_ok, 1);
      cyc(0,1,0,4'b0000,8'd0);
      chk("scan_open.state", a_state, 2);
      chk("scan_open.count3", a_counts[3*21 +: 21], 1);
      cyc(1,1,1,4'b0100,8'd0);
      chk("midrst.state", a_state, 0);
      chk("midrst.counts", a_counts, 0);
      chk("midrst.total", a_total, 0);
      chk("midrst.rej_count", a_rc, 0);
      chk("midrst.winner", a_win, 0);
      chk("midrst.tie", a_tie, 0);
      chk("midrst.vote_ok", a_ok, 0);
      chk("midrst.vote_rej", a_rej, 0);
      chk("midrst.rv", a_rv, 0);
      cyc(0,0,0,4'b0000,8'd0);
      chk("midrst.hold_state", a_state, 0);

      // eight candidates: votes 7,7,5
      cyc(1,0,0,4'b0000,8'd0);
      cyc(0,1,0,4'b0000,8'd0);
      cyc(0,0,0,4'b0000,8'h80);
      cyc(0,0,0,4'b0000,8'h80);
      cyc(0,0,0,4'b0000,8'h20);
      chk("c8.total", e_total, 3);
      cyc(0,0,1,4'b0000,8'd0);
      chk("c8.state_scan", e_state, 2);
      wait_rv(1'b1, "c8.latency", 9);
      chk("c8.winner", e_win, 7);
      chk("c8.tie", e_tie, 0);
      chk("c8.count5", e_counts[5*21 +: 21], 1);
      chk("c8.count7", e_counts[7*21 +: 21], 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
